// File: rtl/mirror_display_pkg.sv
// Shared definitions for the mirror display selector and any other
// Mirror_Display users: the selector codes that drive the mux SS input,
// the button FSM state encoding and a small helper for stepping the selector.
package mirror_display_pkg;

   localparam logic [1:0] SEL_TEMPERATURE = 2'd0;
   localparam logic [1:0] SEL_AVG_MPG     = 2'd1;
   localparam logic [1:0] SEL_INST_MPG    = 2'd2;
   localparam logic [1:0] SEL_MILES_REM   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DB_PRESS = 2'd1,
      ST_HELD     = 2'd2,
      ST_DB_REL   = 2'd3
   } state_e;

   // Miles remaining wraps back to Temperature through the natural 2-bit overflow.
   function automatic logic [1:0] nextSel(input logic [1:0] sel);
      return sel + 2'd1;
   endfunction

endpackage

// File: rtl/mirror_display_selector_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// Both flops clear on the asynchronous active-low reset.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // The first flop may go metastable; the second gives it a full cycle to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/mirror_display_selector.sv
// Mirror display selector: turns one dashboard pushbutton into the 2-bit SS
// code for the mirror display mux. The button is synchronised and debounced;
// each accepted press steps SS, and a long hold forces it back to Temperature.
// Optional build macro AUTO_SCROLL_EN adds a dwell timer that steps SS on its
// own while auto_en is high and the button is idle.
module mirror_display_selector
   import mirror_display_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 50000,
   parameter int LONG_PRESS_CYCLES = 2000000,
   parameter int DWELL_CYCLES      = 5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_raw,
   input  logic       auto_en,
   output logic [1:0] ss,
   output logic       ss_changed
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(LONG_PRESS_CYCLES);

   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX  = {HW{1'b1}};

   logic          btnS;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic          longDone_q, longDone_d;
   logic [1:0]    ss_q, ss_d;
   logic          ssChanged_q;
   logic          btnAdvance;
   logic          longClear;
   logic          dwellExpire;

   sync_2ff uBtnSync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (btn_raw),
      .q_o   (btnS)
   );

   // State register: FSM state, debounce/hold counters, selector and change pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hcnt_q      <= '0;
         longDone_q  <= 1'b0;
         ss_q        <= SEL_TEMPERATURE;
         ssChanged_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hcnt_q      <= hcnt_d;
         longDone_q  <= longDone_d;
         ss_q        <= ss_d;
         ssChanged_q <= (ss_d != ss_q);
      end
   end

   // Next-state logic: debounce press and release, then time the hold.
   // Bounce during release drops back to HELD without touching the selector,
   // so a single press can only ever advance SS once.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hcnt_d     = hcnt_q;
      longDone_d = longDone_q;
      btnAdvance = 1'b0;
      longClear  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (btnS) begin
               state_d = ST_DB_PRESS;
               cnt_d   = '0;
            end
         end
         ST_DB_PRESS: begin
            if (!btnS) begin
               state_d = ST_IDLE;
            end else if (cnt_q == DEB_LAST) begin
               state_d    = ST_HELD;
               hcnt_d     = '0;
               longDone_d = 1'b0;
               btnAdvance = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HELD: begin
            if (hcnt_q != HOLD_MAX) begin
               hcnt_d = hcnt_q + 1'b1;
            end
            if ((hcnt_q == HOLD_LAST) && !longDone_q) begin
               longClear  = 1'b1;
               longDone_d = 1'b1;
            end
            if (!btnS) begin
               state_d = ST_DB_REL;
               cnt_d   = '0;
            end
         end
         ST_DB_REL: begin
            if (btnS) begin
               state_d = ST_HELD;
            end else if (cnt_q == DEB_LAST) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic: long hold wins over any advance; a button advance and a
   // dwell expiry in the same cycle still step the selector only once.
   always_comb begin
      ss_d = ss_q;
      if (longClear) begin
         ss_d = SEL_TEMPERATURE;
      end else if (btnAdvance || dwellExpire) begin
         ss_d = nextSel(ss_q);
      end
   end

`ifdef AUTO_SCROLL_EN
   localparam int DW = $clog2(DWELL_CYCLES);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

   logic [DW-1:0] dwell_q, dwell_d;

   // Dwell timer only runs while auto-scroll is requested and the button is idle.
   always_comb begin
      dwell_d     = dwell_q;
      dwellExpire = 1'b0;
      if (!auto_en || (state_q != ST_IDLE) || btnAdvance) begin
         dwell_d = '0;
      end else if (dwell_q == DWELL_LAST) begin
         dwell_d     = '0;
         dwellExpire = 1'b1;
      end else begin
         dwell_d = dwell_q + 1'b1;
      end
   end

   // Dwell counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell_q <= '0;
      end else begin
         dwell_q <= dwell_d;
      end
   end
`else
   logic unusedAutoEn;
   assign unusedAutoEn = auto_en;
   assign dwellExpire  = 1'b0;
`endif

   assign ss         = ss_q;
   assign ss_changed = ssChanged_q;

endmodule

// File: tb/tb_mirror_display_selector.sv
// Testbench for mirror_display_selector with short debounce/hold/dwell times.
// Every ss_changed pulse is matched against a queue of expected selector
// values; directed checks cover reset, latency, glitches and long holds.
module tb_mirror_display_selector;

   logic       clk;
   logic       rst_n;
   logic       btn_raw;
   logic       auto_en;
   logic [1:0] ss;
   logic       ss_changed;

   int         vectors;
   int         miscompares;
   logic [1:0] sbQ[$];
   logic [1:0] monExp;

   mirror_display_selector #(
      .DEBOUNCE_CYCLES   (4),
      .LONG_PRESS_CYCLES (20),
      .DWELL_CYCLES      (10)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .auto_en    (auto_en),
      .ss         (ss),
      .ss_changed (ss_changed)
   );

   // Free-running 10ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so a stuck run still ends with a report.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Hold the button for a number of cycles, release, and let the release debounce finish.
   task automatic applyStimulus(input int holdCycles);
      @(negedge clk);
      btn_raw = 1'b1;
      repeat (holdCycles) @(negedge clk);
      btn_raw = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   // Scoreboard monitor: each change pulse must match the next expected selector value.
   always @(negedge clk) begin
      if (rst_n && ss_changed) begin
         if (sbQ.size() == 0) begin
            checkOutput("sb_unexpected_pulse", {30'd0, ss}, 32'hFFFF_FFFF);
         end else begin
            monExp = sbQ.pop_front();
            checkOutput("sb_ss", {30'd0, ss}, {30'd0, monExp});
         end
      end
   end

   // Directed sequence of steps.
   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      btn_raw     = 1'b0;
      auto_en     = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_ss", {30'd0, ss}, 32'd0);
      checkOutput("reset_pulse", {31'd0, ss_changed}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Clean press: the first edge samples the rise, ss moves 6 cycles later.
      sbQ.push_back(2'd1);
      btn_raw = 1'b1;
      repeat (6) @(posedge clk);
      #1 checkOutput("t1_before_latency", {30'd0, ss}, 32'd0);
      @(posedge clk);
      #1 checkOutput("t1_at_latency", {30'd0, ss}, 32'd1);
      checkOutput("t1_pulse", {31'd0, ss_changed}, 32'd1);
      @(posedge clk);
      #1 checkOutput("t1_pulse_width", {31'd0, ss_changed}, 32'd0);
      repeat (2) @(negedge clk);
      btn_raw = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("t1_after_release", {30'd0, ss}, 32'd1);

      // Four presses step through the wrap.
      for (int k = 0; k < 4; k++) begin
         logic [1:0] expSs;
         expSs = 2'(k + 2);
         sbQ.push_back(expSs);
         applyStimulus(10);
         checkOutput("t2_step", {30'd0, ss}, {30'd0, expSs});
      end

      // Short glitches are rejected.
      for (int g = 1; g <= 3; g++) begin
         applyStimulus(g);
         checkOutput("t3_glitch", {30'd0, ss}, 32'd1);
      end

      // Release bounce gives one advance only.
      sbQ.push_back(2'd2);
      @(negedge clk);
      btn_raw = 1'b1;
      repeat (10) @(negedge clk);
      btn_raw = 1'b0;
      @(negedge clk);
      btn_raw = 1'b1;
      repeat (2) @(negedge clk);
      btn_raw = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("t3_release_bounce", {30'd0, ss}, 32'd2);

      // Long hold from ss=2: advance to 3, then forced to 0 at hcnt=19.
      sbQ.push_back(2'd3);
      sbQ.push_back(2'd0);
      btn_raw = 1'b1;
      repeat (7) @(posedge clk);
      #1 checkOutput("t4_accept", {30'd0, ss}, 32'd3);
      repeat (19) @(posedge clk);
      #1 checkOutput("t4_before_long", {30'd0, ss}, 32'd3);
      @(posedge clk);
      #1 checkOutput("t4_long", {30'd0, ss}, 32'd0);
      checkOutput("t4_long_pulse", {31'd0, ss_changed}, 32'd1);
      repeat (13) @(negedge clk);
      btn_raw = 1'b0;
      repeat (12) @(negedge clk);
      checkOutput("t4_after_release", {30'd0, ss}, 32'd0);

      // Reset in the middle of a held press.
      sbQ.push_back(2'd1);
      applyStimulus(10);
      sbQ.push_back(2'd2);
      btn_raw = 1'b1;
      repeat (7) @(posedge clk);
      #1 checkOutput("t5_held", {30'd0, ss}, 32'd2);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1 checkOutput("t5_async_reset", {30'd0, ss}, 32'd0);
      checkOutput("t5_reset_pulse", {31'd0, ss_changed}, 32'd0);
      repeat (2) @(negedge clk);
      sbQ.push_back(2'd1);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1 checkOutput("t5_before_latency", {30'd0, ss}, 32'd0);
      @(posedge clk);
      #1 checkOutput("t5_fresh_press", {30'd0, ss}, 32'd1);
      @(negedge clk);
      btn_raw = 1'b0;
      repeat (12) @(negedge clk);

`ifdef AUTO_SCROLL_EN
      // Auto-scroll steps every 10 idle cycles.
      auto_en = 1'b1;
      sbQ.push_back(2'd2);
      sbQ.push_back(2'd3);
      sbQ.push_back(2'd0);
      repeat (9) @(posedge clk);
      #1 checkOutput("t6_before_dwell", {30'd0, ss}, 32'd1);
      @(posedge clk);
      #1 checkOutput("t6_dwell1", {30'd0, ss}, 32'd2);
      repeat (10) @(posedge clk);
      #1 checkOutput("t6_dwell2", {30'd0, ss}, 32'd3);
      repeat (10) @(posedge clk);
      #1 checkOutput("t6_dwell3", {30'd0, ss}, 32'd0);
      sbQ.push_back(2'd1);
      applyStimulus(10);
      auto_en = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("t6_press_single", {30'd0, ss}, 32'd1);
`else
      // Without auto-scroll, auto_en has no effect.
      auto_en = 1'b1;
      repeat (30) @(negedge clk);
      checkOutput("t6_auto_ignored", {30'd0, ss}, 32'd1);
      auto_en = 1'b0;
`endif

      repeat (2) @(negedge clk);
      checkOutput("sb_drained", sbQ.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
